// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: immediate format selector, major opcodes and a
// signed-range helper used by the immediate packer and extension stage.
package riscv_pkg;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100
   } imm_src_e;

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] LUI    = 7'b0110111;

   // True when v[31:lsb] are all equal, i.e. v fits in an (lsb+1)-bit signed field.
   function automatic logic fits_signed(input logic [31:0] v, input int unsigned lsb);
      logic [31:0] t;
      t = $signed(v) >>> lsb;
      return (t == 32'h0000_0000) || (t == 32'hFFFF_FFFF);
   endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational scatter of a 32-bit immediate into the RV32I field positions
// of the selected format, with a representability check.
module imm_pack
   import riscv_pkg::*;
(
   input  logic [31:0] base,
   input  logic [31:0] imm,
   input  logic [2:0]  immsrc,
   output logic [31:0] instr,
   output logic        err
);

   always_comb begin
      instr = base;
      err   = 1'b0;
      case (imm_src_e'(immsrc))
         IMM_I: begin
            instr[31:20] = imm[11:0];
            err          = !fits_signed(imm, 11);
         end
         IMM_S: begin
            instr[31:25] = imm[11:5];
            instr[11:7]  = imm[4:0];
            err          = !fits_signed(imm, 11);
         end
         IMM_B: begin
            instr[31]    = imm[12];
            instr[30:25] = imm[10:5];
            instr[11:8]  = imm[4:1];
            instr[7]     = imm[11];
            err          = imm[0] || !fits_signed(imm, 12);
         end
         IMM_J: begin
            instr[31]    = imm[20];
            instr[30:21] = imm[10:1];
            instr[20]    = imm[11];
            instr[19:12] = imm[19:12];
            err          = imm[0] || !fits_signed(imm, 20);
         end
         IMM_U: begin
            instr[31:12] = imm[31:12];
            err          = (imm[11:0] != 12'h000);
         end
         // Reserved selectors leave the template untouched and flag the request.
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready pipeline around imm_pack, with a saturating count
// of errored results handed downstream.
module imm_encoder
   import riscv_pkg::*;
#(
   parameter int ERR_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_base,
   input  logic [31:0]          in_imm,
   input  logic [2:0]           in_immsrc,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_instr,
   output logic                 out_err,
   output logic [ERR_CNT_W-1:0] err_count
);

   // Handshake: a beat moves on a rising edge where valid and ready are both
   // high; a stage advances when it is empty or the stage after it advances.
   logic                 r_s1_valid;
   logic                 r_s1_err;
   logic [31:0]          r_s1_instr;
   logic                 r_s2_valid;
   logic                 r_s2_err;
   logic [31:0]          r_s2_instr;
   logic [ERR_CNT_W-1:0] r_err_count;
   logic                 w_adv1;
   logic                 w_adv2;
   logic [31:0]          w_pack_instr;
   logic                 w_pack_err;

   imm_pack u_pack (
      .base   (in_base),
      .imm    (in_imm),
      .immsrc (in_immsrc),
      .instr  (w_pack_instr),
      .err    (w_pack_err)
   );

   assign w_adv2    = !r_s2_valid || out_ready;
   assign w_adv1    = !r_s1_valid || w_adv2;
   assign in_ready  = w_adv1;
   assign out_valid = r_s2_valid;
   assign out_instr = r_s2_instr;
   assign out_err   = r_s2_err;
   assign err_count = r_err_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_valid  <= 1'b0;
         r_s1_err    <= 1'b0;
         r_s1_instr  <= 32'h0;
         r_s2_valid  <= 1'b0;
         r_s2_err    <= 1'b0;
         r_s2_instr  <= 32'h0;
         r_err_count <= '0;
      end else begin
         if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
               r_s1_instr <= w_pack_instr;
               r_s1_err   <= w_pack_err;
            end
         end
         if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_s2_instr <= r_s1_instr;
               r_s2_err   <= r_s1_err;
            end
         end
         if (r_s2_valid && out_ready && r_s2_err && (r_err_count != {ERR_CNT_W{1'b1}}))
            r_err_count <= r_err_count + ERR_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed vector table, backpressure/reset/saturation
// sequences, and a randomized stream scored against an arithmetic model.
module tb_imm_encoder;

   localparam int CW   = 6;
   localparam int CMAX = (1 << CW) - 1;
   localparam int W    = 68;

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_base;
   logic [31:0]   in_imm;
   logic [2:0]    in_immsrc;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_instr;
   logic          out_err;
   logic [CW-1:0] err_count;

   int n_checks = 0;
   int n_fail   = 0;
   int model_cnt = 0;
   logic [W-1:0] exp_q[$];
   logic        prev_stall = 1'b0;
   logic [31:0] prev_instr;
   logic        prev_err;

   imm_encoder #(.ERR_CNT_W(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_base   (in_base),
      .in_imm    (in_imm),
      .in_immsrc (in_immsrc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_err   (out_err),
      .err_count (err_count)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   function automatic void ref_pack(input logic [31:0] b, input logic [31:0] m,
                                    input logic [2:0] s,
                                    output logic [31:0] instr, output logic err);
      longint si;
      si = longint'($signed(m));
      case (s)
         3'd0: begin instr = {m[11:0], b[19:0]};
                     err = !(si >= -2048 && si <= 2047); end
         3'd1: begin instr = {m[11:5], b[24:12], m[4:0], b[6:0]};
                     err = !(si >= -2048 && si <= 2047); end
         3'd2: begin instr = {m[12], m[10:5], b[24:12], m[4:1], m[11], b[6:0]};
                     err = m[0] || !(si >= -4096 && si <= 4095); end
         3'd3: begin instr = {m[20], m[10:1], m[11], m[19:12], b[11:0]};
                     err = m[0] || !(si >= -1048576 && si <= 1048575); end
         3'd4: begin instr = {m[31:12], b[11:0]};
                     err = (m % 4096) != 0; end
         default: begin instr = b; err = 1'b1; end
      endcase
   endfunction

   // Immediate-extension stage, used for the round-trip property.
   function automatic logic [31:0] ref_ext(input logic [31:0] i, input logic [2:0] s);
      case (s)
         3'd0: return {{20{i[31]}}, i[31:20]};
         3'd1: return {{20{i[31]}}, i[31:25], i[11:7]};
         3'd2: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         3'd3: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         default: return {i[31:12], 12'h000};
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin
      logic [W-1:0] e;
      logic [31:0]  e_instr;
      logic         e_err;
      chk("err_count", 32'(err_count), 32'(model_cnt));
      if (reset) begin
         exp_q.delete();
         model_cnt  = 0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_instr", out_instr, prev_instr);
            chk("stall_err", 32'(out_err), 32'(prev_err));
         end
         if (in_valid && in_ready) begin
            ref_pack(in_base, in_imm, in_immsrc, e_instr, e_err);
            exp_q.push_back({in_imm, in_immsrc, e_err, e_instr});
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output: got %h with nothing expected", out_instr);
            end else begin
               e = exp_q.pop_front();
               chk("out_instr", out_instr, e[31:0]);
               chk("out_err", 32'(out_err), 32'(e[32]));
               if (!e[32])
                  chk("round_trip", ref_ext(out_instr, e[35:33]), e[67:36]);
               if (e[32] && model_cnt != CMAX) model_cnt++;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_instr = out_instr;
         prev_err   = out_err;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      in_valid = 1'b0;
      reset    = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
   task automatic send(input logic [2:0] s, input logic [31:0] b, input logic [31:0] m);
      int t = 0;
      in_immsrc = s; in_base = b; in_imm = m; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && t < 100) begin @(negedge clk); t++; end
      if (!in_ready) begin
         n_checks++; n_fail++;
         $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", t);
      end
      @(posedge clk); #1 in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int t = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || out_valid) && t < 500) begin @(negedge clk); t++; end
      n_checks++;
      if (exp_q.size() != 0 || out_valid) begin
         n_fail++;
         $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic gen_req(input bit errs_only);
      logic [31:0] r;
      r = $urandom;
      in_base = $urandom;
      if (errs_only) begin
         in_immsrc = 3'd4;
         in_imm    = r | 32'h1;
      end else begin
         in_immsrc = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         case ($urandom_range(0, 3))
            0: in_imm = r;
            1: in_imm = {{19{r[12]}}, r[12:0]};
            2: in_imm = r & 32'hFFFF_F000;
            default: in_imm = {{11{r[20]}}, r[20:1], 1'b0};
         endcase
      end
   endtask

   task automatic stream(input int n, input bit errs_only, input bit rand_ready);
      int issued = 0;
      int done = 0;
      int t = 0;
      logic acc;
      in_valid = 1'b0;
      while (done < n && t < 20000) begin
         if (!in_valid && issued < n && (!rand_ready || $urandom_range(0, 4) != 0)) begin
            gen_req(errs_only);
            in_valid = 1'b1;
            issued++;
         end
         out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) begin in_valid = 1'b0; done++; end
         t++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      n_checks++;
      if (done < n) begin
         n_fail++;
         $display("FAIL stream_timeout: accepted %0d of %0d", done, n);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [2:0]  src;
      logic [31:0] base;
      logic [31:0] imm;
      logic [31:0] exp_instr;
      logic        exp_err;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int n_err_vec;
      logic [31:0] bp_imm[3];
      int idx;

      vecs[0]  = '{3'd0, 32'h0000_0013, 32'hFFFF_FFFF, 32'hFFF0_0013, 1'b0};
      vecs[1]  = '{3'd0, 32'h0000_0013, 32'h0000_07FF, 32'h7FF0_0013, 1'b0};
      vecs[2]  = '{3'd2, 32'h0000_0063, 32'h0000_0FFE, 32'h7E00_0FE3, 1'b0};
      vecs[3]  = '{3'd2, 32'h0000_0063, 32'h0000_0001, 32'h0000_0063, 1'b1};
      vecs[4]  = '{3'd4, 32'h0000_0537, 32'h1234_5000, 32'h1234_5537, 1'b0};
      vecs[5]  = '{3'd4, 32'h0000_0537, 32'h1234_5001, 32'h1234_5537, 1'b1};
      vecs[6]  = '{3'd7, 32'h0000_0537, 32'h1234_5000, 32'h0000_0537, 1'b1};
      vecs[7]  = '{3'd3, 32'h0000_006F, 32'hFFFF_FFFE, 32'hFFFF_F06F, 1'b0};
      vecs[8]  = '{3'd3, 32'h0000_006F, 32'h0010_0000, 32'h8000_006F, 1'b1};
      vecs[9]  = '{3'd1, 32'h0000_2023, 32'hFFFF_F800, 32'h8000_2023, 1'b0};
      vecs[10] = '{3'd1, 32'h0000_2023, 32'h0000_0800, 32'h8000_2023, 1'b1};
      vecs[11] = '{3'd5, 32'h0000_0013, 32'h0000_0000, 32'h0000_0013, 1'b1};

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_base = '0; in_imm = '0; in_immsrc = '0;
      do_reset();
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_instr", out_instr, 32'h0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      @(posedge clk); #1;

      // Directed vectors, one at a time, with latency check.
      n_err_vec = 0;
      for (int i = 0; i < 12; i++) begin
         send(vecs[i].src, vecs[i].base, vecs[i].imm);
         @(negedge clk);
         chk("lat1_valid", 32'(out_valid), 32'd0);
         @(negedge clk);
         chk("lat2_valid", 32'(out_valid), 32'd1);
         chk("vec_instr", out_instr, vecs[i].exp_instr);
         chk("vec_err", 32'(out_err), 32'(vecs[i].exp_err));
         if (vecs[i].exp_err) n_err_vec++;
         @(posedge clk); #1;
      end
      chk("vec_err_count", 32'(err_count), 32'(n_err_vec));

      // Backpressure: three back-to-back offers with the output stalled.
      bp_imm[0] = 32'h0000_0011; bp_imm[1] = 32'h0000_0022; bp_imm[2] = 32'h0000_0033;
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1; in_immsrc = 3'd0; in_base = 32'h0000_0013; in_imm = bp_imm[idx];
         @(negedge clk);
         if (in_valid && in_ready) idx++;
         @(posedge clk); #1;
      end
      chk("bp_accepted", 32'(idx), 32'd2);
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int c = 0; c < 20 && idx < 3; c++) begin
         in_imm = bp_imm[idx];
         @(negedge clk);
         if (in_valid && in_ready) idx++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("bp_all_accepted", 32'(idx), 32'd3);
      wait_drain();

      // Randomized stream with random backpressure.
      do_reset();
      stream(400, 1'b0, 1'b1);
      wait_drain();

      // Reset with both stages full and five errors counted.
      do_reset();
      stream(5, 1'b1, 1'b0);
      wait_drain();
      chk("pre_rst_count", 32'(err_count), 32'd5);
      out_ready = 1'b0;
      send(3'd0, 32'h0000_0013, 32'h0000_0001);
      send(3'd0, 32'h0000_0013, 32'h0000_0002);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_err_count", 32'(err_count), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("mid_rst_no_stale", 32'(out_valid), 32'd0);
      end
      @(posedge clk); #1;

      // Saturation of the error counter.
      do_reset();
      stream(CMAX + 8, 1'b1, 1'b0);
      wait_drain();
      chk("sat_err_count", 32'(err_count), 32'(CMAX));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
